// File: rtl/ads1284_seq_ctrl.sv
// ads1284_seq_ctrl: ADS1284 command sequencer (SDATAC once, WREG config writes, DRDY-paced RDATA reads)
module ads1284_seq_ctrl #(
  parameter int          DRDY_TIMEOUT = 65535,
  parameter logic [7:0]  CMD_SDATAC   = 8'h11,
  parameter logic [7:0]  CMD_RDATA    = 8'h12,
  parameter logic [7:0]  CMD_WREG     = 8'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_conv,
  input  logic        stop_conv,
  input  logic        cfg_req,
  input  logic [3:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  output logic        cfg_ack,
  input  logic        drdy_n,
  output logic        spi_tx_valid,
  output logic [7:0]  spi_tx_data,
  output logic        spi_tx_last,
  input  logic        spi_tx_ready,
  input  logic        spi_rx_valid,
  input  logic [7:0]  spi_rx_data,
  output logic [31:0] sample_data,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err
);
  localparam int CW = $clog2(DRDY_TIMEOUT);
  typedef enum logic [3:0] {INIT, IDLE, CFG_OP, CFG_CNT, CFG_DAT, WAIT_DRDY,
                            RD_CMD, RD_B0, RD_B1, RD_B2, RD_B3} state_t;
  state_t        state_q, state_d;
  logic          pend_q, pend_d, run_q, run_d;
  logic          tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
  logic [7:0]    tx_data_q, tx_data_d, wreg_data_q, wreg_data_d;
  logic [3:0]    wreg_addr_q, wreg_addr_d;
  logic [23:0]   shift_q, shift_d;
  logic [31:0]   sample_data_q, sample_data_d;
  logic          sample_valid_q, sample_valid_d, cfg_ack_q, cfg_ack_d;
  logic          busy_q, busy_d, timeout_err_q, timeout_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sync_q, sync_d;
  logic          fire, fall, sending, offer, take_cfg, in_rd, stay_wait;
  logic [7:0]    tx_byte;
  always_comb begin
    fire           = pend_q & spi_rx_valid;
    fall           = sync_q[2] & ~sync_q[1];
    sending        = !(state_q inside {IDLE, WAIT_DRDY});
    offer          = sending & ~pend_q & ~tx_valid_q;
    tx_byte        = state_q == INIT    ? CMD_SDATAC :
                     state_q == CFG_OP  ? (CMD_WREG | {4'h0, wreg_addr_q}) :
                     state_q == CFG_DAT ? wreg_data_q :
                     state_q == RD_CMD  ? CMD_RDATA : 8'h00;
    tx_valid_d     = offer | (tx_valid_q & ~spi_tx_ready);
    tx_data_d      = offer ? tx_byte : tx_data_q;
    tx_last_d      = offer ? (state_q inside {INIT, CFG_DAT, RD_B3}) : tx_last_q;
    pend_d         = (tx_valid_q & spi_tx_ready) | (pend_q & ~spi_rx_valid);
    run_d          = ~stop_conv & (start_conv | run_q);
    state_d        = state_q;
    case (state_q)
      INIT:      state_d = fire ? IDLE : INIT;
      IDLE:      state_d = cfg_req ? CFG_OP : run_q ? WAIT_DRDY : IDLE;
      CFG_OP:    state_d = fire ? CFG_CNT : CFG_OP;
      CFG_CNT:   state_d = fire ? CFG_DAT : CFG_CNT;
      CFG_DAT:   state_d = fire ? IDLE : CFG_DAT;
      WAIT_DRDY: state_d = cfg_req ? CFG_OP : !run_q ? IDLE : fall ? RD_CMD : WAIT_DRDY;
      RD_CMD:    state_d = fire ? RD_B0 : RD_CMD;
      RD_B0:     state_d = fire ? RD_B1 : RD_B0;
      RD_B1:     state_d = fire ? RD_B2 : RD_B1;
      RD_B2:     state_d = fire ? RD_B3 : RD_B2;
      RD_B3:     state_d = fire ? WAIT_DRDY : RD_B3;
      default:   state_d = INIT;
    endcase
    take_cfg       = (state_q inside {IDLE, WAIT_DRDY}) & cfg_req;
    wreg_addr_d    = take_cfg ? cfg_addr : wreg_addr_q;
    wreg_data_d    = take_cfg ? cfg_data : wreg_data_q;
    in_rd          = state_q inside {RD_B0, RD_B1, RD_B2, RD_B3};
    shift_d        = (fire & in_rd) ? {shift_q[15:0], spi_rx_data} : shift_q;
    sample_valid_d = fire & (state_q == RD_B3);
    sample_data_d  = sample_valid_d ? {shift_q, spi_rx_data} : sample_data_q;
    cfg_ack_d      = fire & (state_q == CFG_DAT);
    stay_wait      = (state_q == WAIT_DRDY) & (state_d == WAIT_DRDY);
    timeout_err_d  = stay_wait & (cnt_q == CW'(DRDY_TIMEOUT - 1));
    cnt_d          = (stay_wait & ~timeout_err_d) ? cnt_q + CW'(1) : '0;
    busy_d         = !(state_d inside {IDLE, WAIT_DRDY});
    sync_d         = {sync_q[1:0], drdy_n};
  end
  // DRDY synchroniser resets high so release from reset never looks like a falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= INIT;
      pend_q         <= 1'b0;
      run_q          <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      tx_last_q      <= 1'b0;
      wreg_addr_q    <= 4'h0;
      wreg_data_q    <= 8'h00;
      shift_q        <= '0;
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
      cfg_ack_q      <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      cnt_q          <= '0;
      sync_q         <= 3'b111;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      run_q          <= run_d;
      tx_valid_q     <= tx_valid_d;
      tx_data_q      <= tx_data_d;
      tx_last_q      <= tx_last_d;
      wreg_addr_q    <= wreg_addr_d;
      wreg_data_q    <= wreg_data_d;
      shift_q        <= shift_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      cfg_ack_q      <= cfg_ack_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
      cnt_q          <= cnt_d;
      sync_q         <= sync_d;
    end
  end
  assign spi_tx_valid = tx_valid_q;
  assign spi_tx_data  = tx_data_q;
  assign spi_tx_last  = tx_last_q;
  assign sample_data  = sample_data_q;
  assign sample_valid = sample_valid_q;
  assign cfg_ack      = cfg_ack_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_ads1284_seq_ctrl.sv
// tb_ads1284_seq_ctrl: directed self-checking bench for the ADS1284 sequencer
module tb_ads1284_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst, start_conv, stop_conv, cfg_req, cfg_ack, drdy_n;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_data, spi_tx_data, spi_rx_data;
  logic        spi_tx_valid, spi_tx_last, spi_tx_ready, spi_rx_valid;
  logic [31:0] sample_data;
  logic        sample_valid, busy, timeout_err;
  int          tests = 0, fails = 0;
  always #5 clk = ~clk;
  ads1284_seq_ctrl #(.DRDY_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start_conv(start_conv), .stop_conv(stop_conv),
    .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .drdy_n(drdy_n), .spi_tx_valid(spi_tx_valid), .spi_tx_data(spi_tx_data),
    .spi_tx_last(spi_tx_last), .spi_tx_ready(spi_tx_ready), .spi_rx_valid(spi_rx_valid),
    .spi_rx_data(spi_rx_data), .sample_data(sample_data), .sample_valid(sample_valid),
    .busy(busy), .timeout_err(timeout_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask
  // one byte slot: wait for the offer, check it, accept, then return the rx byte
  task automatic xfer(input string tag, input logic [7:0] exp_data, input logic exp_last,
                      input logic [7:0] rx);
    int n = 0;
    while (!spi_tx_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_offer"}, {31'd0, spi_tx_valid}, 32'd1);
    if (!spi_tx_valid) return;
    chk({tag, "_data"}, {24'd0, spi_tx_data}, {24'd0, exp_data});
    chk({tag, "_last"}, {31'd0, spi_tx_last}, {31'd0, exp_last});
    spi_tx_ready = 1'b1;
    @(negedge clk);
    spi_tx_ready = 1'b0;
    chk({tag, "_drop"}, {31'd0, spi_tx_valid}, 32'd0);
    @(negedge clk);
    spi_rx_valid = 1'b1;
    spi_rx_data  = rx;
    @(negedge clk);
    spi_rx_valid = 1'b0;
  endtask
  task automatic pulse_run(input logic s, input logic p);
    start_conv = s;
    stop_conv  = p;
    @(negedge clk);
    start_conv = 1'b0;
    stop_conv  = 1'b0;
  endtask
  initial begin
    int n, pulses, first, txs;
    rst = 1'b1; start_conv = 1'b0; stop_conv = 1'b0; cfg_req = 1'b0;
    cfg_addr = 4'h0; cfg_data = 8'h00; drdy_n = 1'b1;
    spi_tx_ready = 1'b0; spi_rx_valid = 1'b0; spi_rx_data = 8'h00;
    cyc(3);
    chk("rst_tx_valid", {31'd0, spi_tx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sample", sample_data, 32'd0);
    chk("rst_flags", {29'd0, sample_valid, cfg_ack, timeout_err}, 32'd0);
    rst = 1'b0;
    // T1: SDATAC after reset
    xfer("t1_sdatac", 8'h11, 1'b1, 8'h00);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    // T2: WREG, with inputs changed after the frame starts
    cfg_addr = 4'h1; cfg_data = 8'h52; cfg_req = 1'b1;
    xfer("t2_op", 8'h41, 1'b0, 8'h00);
    cfg_addr = 4'hF; cfg_data = 8'hFF;
    xfer("t2_cnt", 8'h00, 1'b0, 8'h00);
    xfer("t2_dat", 8'h52, 1'b1, 8'h00);
    chk("t2_ack", {31'd0, cfg_ack}, 32'd1);
    cfg_req = 1'b0;
    @(negedge clk);
    chk("t2_ack_once", {31'd0, cfg_ack}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    // T3: sample read
    pulse_run(1'b1, 1'b0);
    drdy_n = 1'b0;
    xfer("t3_cmd", 8'h12, 1'b0, 8'h00);
    drdy_n = 1'b1;
    xfer("t3_b0", 8'h00, 1'b0, 8'h12);
    xfer("t3_b1", 8'h00, 1'b0, 8'h34);
    xfer("t3_b2", 8'h00, 1'b0, 8'h56);
    xfer("t3_b3", 8'h00, 1'b1, 8'h78);
    chk("t3_valid", {31'd0, sample_valid}, 32'd1);
    chk("t3_data", sample_data, 32'h12345678);
    @(negedge clk);
    chk("t3_valid_once", {31'd0, sample_valid}, 32'd0);
    // T4: cfg_req during a sample frame waits for it
    drdy_n = 1'b0;
    xfer("t4_cmd", 8'h12, 1'b0, 8'h00);
    cfg_addr = 4'h3; cfg_data = 8'hA5; cfg_req = 1'b1;
    drdy_n = 1'b1;
    xfer("t4_b0", 8'h00, 1'b0, 8'hAA);
    xfer("t4_b1", 8'h00, 1'b0, 8'hBB);
    xfer("t4_b2", 8'h00, 1'b0, 8'hCC);
    xfer("t4_b3", 8'h00, 1'b1, 8'hDD);
    chk("t4_data", sample_data, 32'hAABBCCDD);
    xfer("t4_op", 8'h43, 1'b0, 8'h00);
    xfer("t4_cnt", 8'h00, 1'b0, 8'h00);
    xfer("t4_dat", 8'hA5, 1'b1, 8'h00);
    chk("t4_ack", {31'd0, cfg_ack}, 32'd1);
    cfg_req = 1'b0;
    // T5: timeout cadence with DRDY idle
    n = 0;
    while (!timeout_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t5_first_pulse", {31'd0, timeout_err}, 32'd1);
    pulses = 0; first = 0; txs = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        pulses++;
        if (first == 0) first = i;
      end
      if (spi_tx_valid) txs++;
    end
    chk("t5_pulses", pulses, 2);
    chk("t5_period", first, 16);
    chk("t5_no_tx", txs, 0);
    // T6: stop+start together mid-frame, then reset mid-frame
    drdy_n = 1'b0;
    xfer("t6_cmd", 8'h12, 1'b0, 8'h00);
    drdy_n = 1'b1;
    xfer("t6_b0", 8'h00, 1'b0, 8'h11);
    pulse_run(1'b1, 1'b1);
    xfer("t6_b1", 8'h00, 1'b0, 8'h22);
    xfer("t6_b2", 8'h00, 1'b0, 8'h33);
    xfer("t6_b3", 8'h00, 1'b1, 8'h44);
    chk("t6_valid", {31'd0, sample_valid}, 32'd1);
    chk("t6_data", sample_data, 32'h11223344);
    cyc(3);
    drdy_n = 1'b0;
    txs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (spi_tx_valid) txs++;
    end
    chk("t6_stopped_no_tx", txs, 0);
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    drdy_n = 1'b1;
    pulse_run(1'b1, 1'b0);
    cyc(3);
    drdy_n = 1'b0;
    xfer("t6r_cmd", 8'h12, 1'b0, 8'h00);
    drdy_n = 1'b1;
    xfer("t6r_b0", 8'h00, 1'b0, 8'h9A);
    xfer("t6r_b1", 8'h00, 1'b0, 8'hBC);
    rst = 1'b1;
    @(negedge clk);
    chk("t6r_tx_valid", {31'd0, spi_tx_valid}, 32'd0);
    chk("t6r_sample", sample_data, 32'd0);
    chk("t6r_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    xfer("t6r_sdatac", 8'h11, 1'b1, 8'h00);
    chk("t6r_idle", {31'd0, busy}, 32'd0);
    chk("t6r_no_sample", {31'd0, sample_valid}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
